// File: rtl/maxnet_controller.sv
// MaxNet winner-take-all engine: loads M activations, then alternates SUM / CHECK / UPDATE
// passes over a circular register file until one cell survives or the iteration cap is reached.
module maxnet_controller #(
    parameter int M         = 10,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(M)-1:0]   winner_idx,
    output logic [7:0]             winner_val,
    output logic                   no_winner,
    output logic [7:0]             iter_count
);

    localparam int IW = $clog2(M);
    localparam int SW = 8 + IW;
    localparam int CW = $clog2(M + 1);
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SUM,
        S_CHECK,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    cells [M];
    logic [IW-1:0] load_cnt;
    logic [IW-1:0] pos;
    logic [SW-1:0] sum;
    logic [CW-1:0] nz_cnt;
    logic [IW-1:0] nz_idx;

    logic [7:0]    cur;
    logic [SW-1:0] inh;
    logic [7:0]    upd;
    logic          last;

    // Inhibition uses the SUM-pass snapshot, so every cell sees the previous iteration's values.
    always_comb begin
        cur  = cells[pos];
        last = (pos == LAST);
        inh  = (sum - SW'(cur)) >> EPS_SHIFT;
        upd  = (inh >= SW'(cur)) ? 8'd0 : cur - inh[7:0];
    end

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_SUM) || (state == S_CHECK) || (state == S_UPDATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            pos        <= '0;
            sum        <= '0;
            nz_cnt     <= '0;
            nz_idx     <= '0;
            iter_count <= '0;
            done       <= 1'b0;
            winner_idx <= '0;
            winner_val <= '0;
            no_winner  <= 1'b0;
            // NOTE: the register file is small and an abort must discard its contents, so it is
            // reset with the rest of the state instead of being left to a RAM macro.
            for (int i = 0; i < M; i++) cells[i] <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments; the default below is overridden
            // by a later assignment in the same cycle, which is the intended last-wins behaviour.
            done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        cells[load_cnt] <= in_data;
                        if (load_cnt == LAST) begin
                            load_cnt   <= '0;
                            pos        <= '0;
                            sum        <= '0;
                            nz_cnt     <= '0;
                            iter_count <= '0;
                            winner_idx <= '0;
                            winner_val <= '0;
                            no_winner  <= 1'b0;
                            state      <= S_SUM;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_SUM: begin
                    sum <= sum + SW'(cur);
                    if (cur != 8'd0) begin
                        nz_cnt <= nz_cnt + 1'b1;
                        nz_idx <= pos;
                    end
                    if (last) begin
                        pos   <= '0;
                        state <= S_CHECK;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (nz_cnt == '0) begin
                        no_winner <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (nz_cnt == CW'(1)) begin
                        winner_idx <= nz_idx;
                        winner_val <= cells[nz_idx];
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (iter_count == 8'(MAX_ITER)) begin
                        no_winner <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    cells[pos] <= upd;
                    if (last) begin
                        pos        <= '0;
                        sum        <= '0;
                        nz_cnt     <= '0;
                        iter_count <= iter_count + 1'b1;
                        state      <= S_SUM;
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                S_DONE:  state <= S_LOAD;
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller (M=4, EPS_SHIFT=2, MAX_ITER=15) with hand-computed
// results, done-cycle timing, backpressure, abort and gapped-load scenarios.
module tb_maxnet_controller;

    localparam int M         = 4;
    localparam int EPS_SHIFT = 2;
    localparam int MAX_ITER  = 15;
    localparam int IW        = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          busy;
    logic          done;
    logic [IW-1:0] winner_idx;
    logic [7:0]    winner_val;
    logic          no_winner;
    logic [7:0]    iter_count;

    int n_checks = 0;
    int n_fail   = 0;

    maxnet_controller #(
        .M(M),
        .EPS_SHIFT(EPS_SHIFT),
        .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .busy(busy),
        .done(done),
        .winner_idx(winner_idx),
        .winner_val(winner_val),
        .no_winner(no_winner),
        .iter_count(iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_beat(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        load_beat(a);
        load_beat(b);
        load_beat(c);
        load_beat(d);
    endtask

    // Counts cycles from the first SUM cycle until done, then checks timing, results and hold.
    task automatic run_check(input string tag, input int exp_cyc, input logic [IW-1:0] e_idx,
                             input logic [7:0] e_val, input logic e_nw, input logic [7:0] e_iter,
                             input logic hold);
        int   cyc   = 0;
        logic bp_ok = 1'b1;
        while (cyc < 1000) begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
            cyc++;
            if (in_ready) bp_ok = 1'b0;
            if (cyc == 1) begin
                check({tag, " cleared val"}, winner_val, 0);
                check({tag, " cleared iter"}, iter_count, 0);
                check({tag, " busy in sum"}, busy, 1);
            end
            if (done) break;
        end
        in_valid = 1'b0;
        check({tag, " done cycle"}, cyc, exp_cyc);
        check({tag, " winner_idx"}, winner_idx, e_idx);
        check({tag, " winner_val"}, winner_val, e_val);
        check({tag, " no_winner"}, no_winner, e_nw);
        check({tag, " iter_count"}, iter_count, e_iter);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " in_ready low while running"}, bp_ok, 1);
        @(negedge clk);
        check({tag, " done pulse width"}, done, 0);
        check({tag, " in_ready after done"}, in_ready, 1);
        check({tag, " winner_val held"}, winner_val, e_val);
        check({tag, " iter_count held"}, iter_count, e_iter);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset winner_idx", winner_idx, 0);
        check("reset winner_val", winner_val, 0);
        check("reset no_winner", no_winner, 0);
        check("reset iter_count", iter_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Four passes: 0,0,13,25 -> 0,0,7,22 -> 0,0,2,21 -> 0,0,0,21; in_valid held high.
        load4(8'd10, 8'd20, 8'd30, 8'd40);
        run_check("seq", 42, 2'd3, 8'd21, 1'b0, 8'd4, 1'b1);

        load4(8'd0, 8'd0, 8'd55, 8'd0);
        run_check("single", 6, 2'd2, 8'd55, 1'b0, 8'd0, 1'b0);

        load4(8'd0, 8'd0, 8'd0, 8'd0);
        run_check("zeros", 6, 2'd0, 8'd0, 1'b1, 8'd0, 1'b0);

        // Tie stalls at 3,3 and runs to the cap.
        load4(8'd40, 8'd40, 8'd0, 8'd0);
        run_check("tie", 141, 2'd0, 8'd0, 1'b1, 8'd15, 1'b0);

        // Abort during the first UPDATE cycle (cycle 6).
        load4(8'd10, 8'd20, 8'd30, 8'd40);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort busy before reset", busy, 1);
        reset = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        check("abort done", done, 0);
        check("abort iter_count", iter_count, 0);
        check("abort winner_val", winner_val, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort in_ready after release", in_ready, 1);

        // Partial load discarded by reset; reload 1,9,1,1 -> 0,9,0,0 after one pass.
        load_beat(8'd200);
        load_beat(8'd200);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load4(8'd1, 8'd9, 8'd1, 8'd1);
        run_check("reload", 15, 2'd1, 8'd9, 1'b0, 8'd1, 1'b0);

        // Gapped load: nothing starts until the fourth beat.
        load_beat(8'd5);
        load_beat(8'd0);
        load_beat(8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("gap idle busy", busy, 0);
        end
        check("gap in_ready", in_ready, 1);
        load_beat(8'd0);
        run_check("gap", 6, 2'd0, 8'd5, 1'b0, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Iterative MaxNet winner-take-all engine for the MaxNet network datapath. It accepts M unsigned 8-bit activations over a valid/ready stream and stores them in an internal M-entry circular register file. It then sequences lateral-inhibition iterations, one cell per cycle, until at most one activation is nonzero or an iteration cap is hit. It reports the winning index and its final value.

## Interface
- M, 10, number of neurons/cells; M ≥ 2
- EPS_SHIFT, 3, inhibition weight ε = 2^-EPS_SHIFT
- MAX_ITER, 255, iteration cap; 1..255
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_data valid
- in_ready  out  1  high only in LOAD state
- in_data  in  8  unsigned activation
- busy  out  1  high in SUM, CHECK and UPDATE states
- done  out  1  one-cycle pulse when result fields become valid
- winner_idx  out  $clog2(M)  index of the surviving cell; 0 if no_winner
- winner_val  out  8  final value of the surviving cell; 0 if no_winner
- no_winner  out  1  all cells zero, or cap reached with ≥2 nonzero
- iter_count  out  8  number of UPDATE passes performed

## Operation
- States: LOAD, SUM, CHECK, UPDATE, DONE. Reset enters LOAD.
- Reset values:
  - all outputs 0 except in_ready, which is 1 (follows LOAD)
  - cells 0, load counter 0, iteration counter 0
- LOAD:
  - A beat is accepted when in_valid && in_ready. It writes cell[load_cnt], then load_cnt increments.
  - The M-th accepted beat moves the state to SUM, clears iter_count and resets load_cnt to 0.
  - in_valid is ignored in every other state.
- SUM: M cycles, visiting cell 0..M-1 in order.
  - Accumulates sum (width 8+$clog2(M), no overflow possible).
  - Counts nonzero cells as nz_cnt.
  - Records the index of the last nonzero cell as nz_idx.
- CHECK: 1 cycle. Evaluated in order:
  - nz_cnt == 0 → DONE, no_winner=1.
  - nz_cnt == 1 → DONE, winner_idx=nz_idx, winner_val=that cell's value.
  - iter_count == MAX_ITER → DONE, no_winner=1.
  - Otherwise → UPDATE.
- UPDATE: M cycles, cell i updated in cycle i.
  - inh = (sum − cell[i]) >> EPS_SHIFT.
  - cell[i] ← (inh ≥ cell[i]) ? 0 : cell[i] − inh.
  - sum is the SUM-pass snapshot, so all cells see the previous iteration's values (synchronous semantics).
  - After the last cell, iter_count increments and the state moves to SUM.
- DONE: 1 cycle.
  - done=1, then the state returns to LOAD.
  - Result fields and iter_count hold until the next SUM entry, which clears them.
- Equal maxima decay together. They either reach zero together (no_winner) or stall at a fixed point and hit MAX_ITER (no_winner).
- Reset mid-operation aborts immediately. Partial loads and cell contents are discarded.

## Timing
- Cycle 1 = first cycle after the M-th accepted beat (first SUM cycle).
- CHECK occurs at cycle M+1 + k·(2M+1), where k is the number of UPDATE passes performed before it.
- done is high at cycle M+2 + k·(2M+1); in_ready is high the following cycle.
- LOAD accepts one beat per cycle; it needs at least M cycles, and in_valid gaps are allowed.
- No result is produced while fewer than M beats have been accepted.

## Test plan
All scenarios use M=4, EPS_SHIFT=2, MAX_ITER=15.
- Load 10,20,30,40 → cells after each pass:
  - pass 1: 0,0,13,25
  - pass 2: 0,0,7,22
  - pass 3: 0,0,2,21
  - pass 4: 0,0,0,21
  - done at cycle 42; winner_idx=3, winner_val=21, iter_count=4, no_winner=0.
- Load 0,0,55,0 → done at cycle 6; winner_idx=2, winner_val=55, iter_count=0.
- Load 0,0,0,0 → done at cycle 6; no_winner=1, winner_idx=0, winner_val=0.
- Load 40,40,0,0 (tie) → both cells stall at 3; done at cycle 6+15·9=141; no_winner=1, iter_count=15.
- Backpressure and abort:
  - Hold in_valid high through a run: in_ready=0 and no beats are taken while busy.
  - Assert reset during UPDATE: all outputs clear, in_ready=1 after release.
  - Reload 1,9,1,1 and confirm winner_idx=1.
- Gapped load: 3 beats, idle for 5 cycles, then the 4th beat → SUM starts only after the 4th beat.
